// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and vector helpers for the interrupt controller.
// The NMI vector offset lives here so the whole address map stays in one place.
package int_ctrl_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // NMI sits one slot above the last maskable line in the vector table.
    function automatic logic [VEC_W-1:0] nmiOffset(input int irqCount);
        return VEC_W'(2 * irqCount);
    endfunction

    function automatic logic [VEC_W-1:0] vecAddr(input logic [VEC_W-1:0] base,
                                                 input logic [IDX_W-1:0] idx);
        return base + {{(VEC_W-IDX_W-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: reports the highest set request index and whether any request is set.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: prioritises IRQ lines, hands a vector to the CPU and auto-clears the winner.
// Optional non-maskable input enabled with macro INT_CTRL_NMI_EN.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               IRQ_COUNT   = 8,
    parameter logic [VEC_W-1:0] VECTOR_BASE = 16'hFFE0
) (
    input  logic                 MCLK,
    input  logic                 reset,
`ifdef INT_CTRL_NMI_EN
    input  logic                 NMIIN,
`endif
    input  logic [IRQ_COUNT-1:0] IRQ,
    input  logic                 GIE,
    input  logic                 INTACK,
    input  logic                 INTDONE,
    output logic                 INTREQ,
    output logic [VEC_W-1:0]     INTADDR,
    output logic                 VECVALID,
    output logic [IRQ_COUNT-1:0] IRQCLR,
    output logic                 SPURIOUS
);

    state_e                 state_q, state_d;
    logic                   intReq_q, intReq_d;
    logic [VEC_W-1:0]       addr_q, addr_d;
    logic                   vecValid_q, vecValid_d;
    logic [IRQ_COUNT-1:0]   irqClr_q, irqClr_d;
    logic                   spurious_q, spurious_d;

    logic [IDX_W-1:0]       encIdx;
    logic                   encValid;
    logic                   nmiPend;
    logic                   cond;

    int_prio_enc #(
        .WIDTH (IRQ_COUNT)
    ) u_prio_enc (
        .req_i   (IRQ),
        .idx_o   (encIdx),
        .valid_o (encValid)
    );

`ifdef INT_CTRL_NMI_EN
    localparam logic [VEC_W-1:0] NMI_VEC = VECTOR_BASE + nmiOffset(IRQ_COUNT);

    logic nmiIn_q;
    logic nmiPend_q, nmiPend_d;
    logic grantNmi_q, grantNmi_d;

    // Latch stays set until the grant that actually serviced it, regardless of GIE.
    always_comb begin
        nmiPend_d  = nmiPend_q;
        grantNmi_d = grantNmi_q;
        if (state_q == GRANT && grantNmi_q) begin
            nmiPend_d  = 1'b0;
            grantNmi_d = 1'b0;
        end
        if (state_q == REQ && INTACK) begin
            grantNmi_d = nmiPend_q;
        end
        if (NMIIN && !nmiIn_q) begin
            nmiPend_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            nmiIn_q    <= 1'b0;
            nmiPend_q  <= 1'b0;
            grantNmi_q <= 1'b0;
        end else begin
            nmiIn_q    <= NMIIN;
            nmiPend_q  <= nmiPend_d;
            grantNmi_q <= grantNmi_d;
        end
    end

    assign nmiPend = nmiPend_q;
`else
    assign nmiPend = 1'b0;
`endif

    assign cond = (GIE && encValid) || nmiPend;

    always_comb begin
        state_d    = state_q;
        intReq_d   = 1'b0;
        addr_d     = addr_q;
        vecValid_d = vecValid_q;
        irqClr_d   = '0;
        spurious_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                vecValid_d = 1'b0;
                if (cond) begin
                    state_d  = REQ;
                    intReq_d = 1'b1;
                end
            end
            REQ: begin
                intReq_d = 1'b1;
                // INTACK takes precedence over a simultaneous INTDONE here.
                if (INTACK) begin
                    state_d    = GRANT;
                    intReq_d   = 1'b0;
                    vecValid_d = 1'b1;
`ifdef INT_CTRL_NMI_EN
                    if (nmiPend) begin
                        addr_d = NMI_VEC;
                    end else
`endif
                    if (GIE && encValid) begin
                        addr_d   = vecAddr(VECTOR_BASE, encIdx);
                        irqClr_d = IRQ_COUNT'(1) << encIdx;
                    end else begin
                        addr_d     = VECTOR_BASE;
                        spurious_d = 1'b1;
                    end
                end else if (!cond) begin
                    state_d  = IDLE;
                    intReq_d = 1'b0;
                end
            end
            GRANT: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (INTDONE) begin
                    state_d    = IDLE;
                    vecValid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                vecValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            intReq_q   <= 1'b0;
            addr_q     <= '0;
            vecValid_q <= 1'b0;
            irqClr_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            intReq_q   <= intReq_d;
            addr_q     <= addr_d;
            vecValid_q <= vecValid_d;
            irqClr_q   <= irqClr_d;
            spurious_q <= spurious_d;
        end
    end

    assign INTREQ   = intReq_q;
    assign INTADDR  = addr_q;
    assign VECVALID = vecValid_q;
    assign IRQCLR   = irqClr_q;
    assign SPURIOUS = spurious_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; NMI steps compile in with INT_CTRL_NMI_EN.
module tb_int_ctrl;

    logic        MCLK;
    logic        reset;
`ifdef INT_CTRL_NMI_EN
    logic        NMIIN;
`endif
    logic [7:0]  IRQ;
    logic        GIE;
    logic        INTACK;
    logic        INTDONE;
    logic        INTREQ;
    logic [15:0] INTADDR;
    logic        VECVALID;
    logic [7:0]  IRQCLR;
    logic        SPURIOUS;

    int checks = 0;
    int errors = 0;

    int_ctrl #(
        .IRQ_COUNT   (8),
        .VECTOR_BASE (16'hFFE0)
    ) dut (
        .MCLK     (MCLK),
        .reset    (reset),
`ifdef INT_CTRL_NMI_EN
        .NMIIN    (NMIIN),
`endif
        .IRQ      (IRQ),
        .GIE      (GIE),
        .INTACK   (INTACK),
        .INTDONE  (INTDONE),
        .INTREQ   (INTREQ),
        .INTADDR  (INTADDR),
        .VECVALID (VECVALID),
        .IRQCLR   (IRQCLR),
        .SPURIOUS (SPURIOUS)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic applyStimulus(input logic [7:0] irq, input logic gie,
                                 input logic ack, input logic done);
        IRQ     = irq;
        GIE     = gie;
        INTACK  = ack;
        INTDONE = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        reset = 1'b1;
`ifdef INT_CTRL_NMI_EN
        NMIIN = 1'b0;
`endif
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();
        checkOutput("rst_intreq", 32'(INTREQ), 32'd0);
        checkOutput("rst_vecvalid", 32'(VECVALID), 32'd0);
        checkOutput("rst_intaddr", 32'(INTADDR), 32'h0000);
        checkOutput("rst_irqclr", 32'(IRQCLR), 32'h00);
        checkOutput("rst_spurious", 32'(SPURIOUS), 32'd0);
        reset = 1'b0;
        stepClock();

        $display("[TB] basic grant IRQ=05");
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t1_intreq", 32'(INTREQ), 32'd1);
        checkOutput("t1_vecvalid_req", 32'(VECVALID), 32'd0);
        applyStimulus(8'h05, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t1_grant_vecvalid", 32'(VECVALID), 32'd1);
        checkOutput("t1_grant_addr", 32'(INTADDR), 32'hFFE4);
        checkOutput("t1_grant_irqclr", 32'(IRQCLR), 32'h04);
        checkOutput("t1_grant_spur", 32'(SPURIOUS), 32'd0);
        checkOutput("t1_grant_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t1_wait_irqclr", 32'(IRQCLR), 32'h00);
        checkOutput("t1_wait_vecvalid", 32'(VECVALID), 32'd1);
        applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t1_wait_irqchg_addr", 32'(INTADDR), 32'hFFE4);
        checkOutput("t1_wait_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h80, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t1_wait_ack_ign_addr", 32'(INTADDR), 32'hFFE4);
        checkOutput("t1_wait_ack_ign_vv", 32'(VECVALID), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t1_done_vecvalid", 32'(VECVALID), 32'd0);
        checkOutput("t1_done_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("idle_ack_ign_intreq", 32'(INTREQ), 32'd0);
        checkOutput("idle_ack_ign_vv", 32'(VECVALID), 32'd0);

        $display("[TB] GIE gating with IRQ=FF");
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            stepClock();
            checkOutput("t2_gie0_intreq", 32'(INTREQ), 32'd0);
        end
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t2_gie1_intreq", 32'(INTREQ), 32'd1);
        applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t2_grant_addr", 32'(INTADDR), 32'hFFEE);
        checkOutput("t2_grant_irqclr", 32'(IRQCLR), 32'h80);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t2_done_vecvalid", 32'(VECVALID), 32'd0);

        $display("[TB] request withdrawn before ack");
        applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("wd_intreq_hi", 32'(INTREQ), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("wd_intreq_lo", 32'(INTREQ), 32'd0);
        stepClock();
        checkOutput("wd_intreq_stay", 32'(INTREQ), 32'd0);
        checkOutput("wd_vecvalid", 32'(VECVALID), 32'd0);

        $display("[TB] spurious ack");
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t3_intreq", 32'(INTREQ), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t3_spurious", 32'(SPURIOUS), 32'd1);
        checkOutput("t3_addr", 32'(INTADDR), 32'hFFE0);
        checkOutput("t3_irqclr", 32'(IRQCLR), 32'h00);
        checkOutput("t3_vecvalid", 32'(VECVALID), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t3_spurious_pulse", 32'(SPURIOUS), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t3_done_vecvalid", 32'(VECVALID), 32'd0);

        $display("[TB] INTACK with INTDONE in REQ");
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(8'h08, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("ackdone_addr", 32'(INTADDR), 32'hFFE6);
        checkOutput("ackdone_irqclr", 32'(IRQCLR), 32'h08);
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("ackdone_wait_vv", 32'(VECVALID), 32'd1);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();

        $display("[TB] reset during WAIT");
        applyStimulus(8'h20, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(8'h20, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t4_grant_addr", 32'(INTADDR), 32'hFFEA);
        applyStimulus(8'h20, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t4_wait_addr", 32'(INTADDR), 32'hFFEA);
        checkOutput("t4_wait_vv", 32'(VECVALID), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_rst_addr", 32'(INTADDR), 32'h0000);
        checkOutput("t4_rst_vv", 32'(VECVALID), 32'd0);
        checkOutput("t4_rst_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        stepClock();
        checkOutput("t4_idle_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("t4_idle_vv", 32'(VECVALID), 32'd0);
        applyStimulus(8'h10, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t4_post_rst_intreq", 32'(INTREQ), 32'd1);
        applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t4_post_rst_addr", 32'(INTADDR), 32'hFFE8);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();

`ifdef INT_CTRL_NMI_EN
        $display("[TB] NMI beats IRQ with GIE low");
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b0);
        NMIIN = 1'b1;
        stepClock();
        stepClock();
        checkOutput("nmi_intreq", 32'(INTREQ), 32'd1);
        applyStimulus(8'h80, 1'b0, 1'b1, 1'b0);
        stepClock();
        checkOutput("nmi_addr", 32'(INTADDR), 32'hFFF0);
        checkOutput("nmi_irqclr", 32'(IRQCLR), 32'h00);
        checkOutput("nmi_spurious", 32'(SPURIOUS), 32'd0);
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b1);
        stepClock();
        stepClock();
        checkOutput("nmi_cleared_intreq", 32'(INTREQ), 32'd0);
        applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("nmi_second_intreq", 32'(INTREQ), 32'd1);
        applyStimulus(8'h80, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("nmi_second_addr", 32'(INTADDR), 32'hFFEE);
        checkOutput("nmi_second_irqclr", 32'(IRQCLR), 32'h80);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
        stepClock();
        stepClock();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter IRQ_COUNT, default 8, the number of maskable request lines (2..15).
REQ-002 SHALL have parameter VECTOR_BASE, default 16'hFFE0, the vector address of IRQ[0].
REQ-003 SHALL have port MCLK, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port IRQ, input, IRQ_COUNT, level requests from peripherals (e.g. TAxINT0/TAxINT1); higher index means higher priority.
REQ-006 SHALL have port GIE, input, 1, CPU status-register global interrupt enable.
REQ-007 SHALL have port INTACK, input, 1, one-cycle CPU pulse starting interrupt entry.
REQ-008 SHALL have port INTDONE, input, 1, one-cycle CPU pulse indicating the vector word was fetched.
REQ-009 SHALL have port INTREQ, output, 1, request to CPU.
REQ-010 SHALL have port INTADDR, output, 16, vector address.
REQ-011 SHALL have port VECVALID, output, 1, INTADDR valid.
REQ-012 SHALL have port IRQCLR, output, IRQ_COUNT, one-hot one-cycle acknowledge to the granted source (drives TAxCLR0-style auto-clear).
REQ-013 SHALL have port SPURIOUS, output, 1, one-cycle pulse on an ack with no active source.

Function
REQ-014 SHALL implement states IDLE, REQ, GRANT, WAIT.
REQ-015 IDLE->REQ SHALL occur on the cycle after (GIE & |IRQ) or a pending NMI is seen; INTREQ SHALL be registered high in REQ.
REQ-016 In REQ, if the qualifying condition drops without INTACK, the FSM SHALL return to IDLE and deassert INTREQ on the next edge.
REQ-017 On INTACK in REQ, the FSM SHALL capture the winner (NMI first, else the highest set IRQ index, evaluated in the INTACK cycle) and enter GRANT.
REQ-018 GRANT SHALL last exactly one cycle: VECVALID=1, INTADDR=VECTOR_BASE+2*idx, IRQCLR[idx]=1; INTREQ SHALL be 0 from GRANT onward.
REQ-019 WAIT SHALL hold INTADDR and VECVALID stable until INTDONE, then go to IDLE; VECVALID=0 in IDLE.
REQ-020 If the condition drops in the same cycle as INTACK (spurious), GRANT SHALL output INTADDR=VECTOR_BASE, pulse SPURIOUS, and leave IRQCLR all zero.
REQ-021 INTACK outside REQ and INTDONE outside WAIT SHALL be ignored.
REQ-022 IRQ changes during GRANT/WAIT SHALL NOT alter INTADDR; new requests are evaluated only in IDLE.
REQ-023 INTACK and INTDONE in the same cycle in REQ SHALL be treated as INTACK only.
REQ-024 Vector arithmetic SHALL be 16-bit unsigned, idx zero-extended and shifted left one.

Reset
REQ-025 reset SHALL force IDLE asynchronously, including mid-GRANT/WAIT, with INTREQ=0, VECVALID=0, INTADDR=16'h0000, IRQCLR=0, SPURIOUS=0, NMI latch=0.

Configuration
REQ-026 With macro INT_CTRL_NMI_EN defined, port NMIIN (input, 1) SHALL exist; its rising edge (registered edge detect) SHALL set an NMI latch independent of GIE; NMI SHALL beat all IRQ lines; its vector SHALL be VECTOR_BASE+2*IRQ_COUNT; the latch SHALL clear in GRANT.
REQ-027 Without INT_CTRL_NMI_EN, NMIIN SHALL be absent and the NMI path SHALL be removed, with behaviour otherwise identical.

Structure
REQ-028 State encodings and the NMI vector offset SHALL live in the shared parameter include alongside the other map constants.
REQ-029 The priority encoder SHALL be a sub-module int_prio_enc (IRQ_COUNT-wide one-hot input, index plus any-valid output).

Verification
REQ-030 GIE=1, IRQ=8'h05, then INTACK -> GRANT gives INTADDR=16'hFFE4, IRQCLR=8'h04, VECVALID held until INTDONE.
REQ-031 GIE=0, IRQ=8'hFF for 20 cycles -> INTREQ stays 0; raise GIE -> INTREQ=1 one cycle later, ack gives INTADDR=16'hFFEE.
REQ-032 IRQ=8'h01, INTREQ=1, IRQ drops to 0 in the same cycle INTACK pulses -> SPURIOUS=1, INTADDR=16'hFFE0, IRQCLR=0.
REQ-033 Assert reset during WAIT with INTADDR=16'hFFEA -> next sample shows INTADDR=0, VECVALID=0, FSM in IDLE.
REQ-034 With INT_CTRL_NMI_EN: NMIIN rising, GIE=0, IRQ=8'h80 -> ack gives INTADDR=16'hFFF0; a second ack gives INTADDR=16'hFFEE after GIE=1.
